// File: rtl/audiodec_dma_gain.sv
// Chunked DMA audio gain stage: reads packed signed 16-bit PCM, scales each lane by a Q8.8 gain, writes it back.
// Optional AUDIODEC_SAT_EN: clamp scaled lanes to the 16-bit range instead of wrapping.
module audiodec_dma_gain #(
  parameter int DMA_WIDTH = 64,
  parameter int CHUNK     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 conf_done,
  input  logic [31:0]          conf_info_cfg_regs_0,
  input  logic [31:0]          conf_info_cfg_regs_1,
  input  logic [31:0]          conf_info_cfg_regs_2,
  input  logic [31:0]          conf_info_cfg_regs_3,
  output logic                 dma_read_ctrl_valid,
  input  logic                 dma_read_ctrl_ready,
  output logic [31:0]          dma_read_ctrl_data_index,
  output logic [31:0]          dma_read_ctrl_data_length,
  output logic [2:0]           dma_read_ctrl_data_size,
  input  logic                 dma_read_chnl_valid,
  output logic                 dma_read_chnl_ready,
  input  logic [DMA_WIDTH-1:0] dma_read_chnl_data,
  output logic                 dma_write_ctrl_valid,
  input  logic                 dma_write_ctrl_ready,
  output logic [31:0]          dma_write_ctrl_data_index,
  output logic [31:0]          dma_write_ctrl_data_length,
  output logic [2:0]           dma_write_ctrl_data_size,
  output logic                 dma_write_chnl_valid,
  input  logic                 dma_write_chnl_ready,
  output logic [DMA_WIDTH-1:0] dma_write_chnl_data,
  output logic                 acc_done,
  output logic [31:0]          debug
);

  localparam int LANES = DMA_WIDTH / 16;
  localparam int AW    = $clog2(CHUNK);
  localparam int CW    = AW + 1;
  localparam logic [2:0] DMA_SIZE = (DMA_WIDTH == 64) ? 3'b011 : 3'b010;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CHECK   = 3'd1;
  localparam logic [2:0] RD_REQ  = 3'd2;
  localparam logic [2:0] RD_DATA = 3'd3;
  localparam logic [2:0] WR_REQ  = 3'd4;
  localparam logic [2:0] WR_DATA = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  logic [2:0]           state;
  logic [31:0]          len_q, src_q, dst_q;
  logic [15:0]          gain_q;
  logic [31:0]          remaining, offset;
  logic [CW-1:0]        count;
  logic                 zero_err;
  logic [7:0]           chunks;
  logic [DMA_WIDTH-1:0] buf_mem [CHUNK];
  logic [DMA_WIDTH-1:0] proc_beat;
  logic [31:0]          cl;
  logic                 last_beat, rd_fire, wr_fire;
  logic                 unused_gain_hi;

  assign unused_gain_hi = ^conf_info_cfg_regs_3[31:16];

  // Signed sample times unsigned Q8.8 gain, then arithmetic shift back to Q0.
  function automatic logic [15:0] scale_lane(input logic [15:0] s, input logic [15:0] g);
    logic signed [32:0] r;
    r = ($signed({{17{s[15]}}, s}) * $signed({17'b0, g})) >>> 8;
`ifdef AUDIODEC_SAT_EN
    if (r > 33'sd32767)       return 16'h7fff;
    else if (r < -33'sd32768) return 16'h8000;
    else                      return r[15:0];
`else
    return r[15:0];
`endif
  endfunction

  // NOTE: combinational blocks assign a default before any branch so no latch is inferred.
  always_comb begin
    proc_beat = '0;
    for (int i = 0; i < LANES; i++)
      proc_beat[16*i +: 16] = scale_lane(dma_read_chnl_data[16*i +: 16], gain_q);
  end

  assign cl        = (remaining < 32'(CHUNK)) ? remaining : 32'(CHUNK);
  assign last_beat = (32'(count) == cl - 32'd1);
  assign rd_fire   = dma_read_chnl_valid && dma_read_chnl_ready;
  assign wr_fire   = dma_write_chnl_valid && dma_write_chnl_ready;

  // NOTE: the chunk buffer is not reset; each entry is written before the write phase reads it.
  always_ff @(posedge clk) begin
    if (rd_fire) buf_mem[count[AW-1:0]] <= proc_beat;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      len_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      gain_q    <= '0;
      remaining <= '0;
      offset    <= '0;
      count     <= '0;
      zero_err  <= 1'b0;
      chunks    <= '0;
    end else begin
      case (state)
        IDLE: if (conf_done) begin
          len_q     <= conf_info_cfg_regs_0;
          src_q     <= conf_info_cfg_regs_1;
          dst_q     <= conf_info_cfg_regs_2;
          gain_q    <= conf_info_cfg_regs_3[15:0];
          remaining <= conf_info_cfg_regs_0;
          offset    <= '0;
          count     <= '0;
          zero_err  <= 1'b0;
          chunks    <= '0;
          state     <= CHECK;
        end
        CHECK: if (len_q == 32'd0) begin
          zero_err <= 1'b1;
          state    <= DONE;
        end else begin
          state <= RD_REQ;
        end
        RD_REQ: if (dma_read_ctrl_ready) state <= RD_DATA;
        RD_DATA: if (rd_fire) begin
          if (last_beat) begin
            count <= '0;
            state <= WR_REQ;
          end else begin
            count <= count + CW'(1);
          end
        end
        WR_REQ: if (dma_write_ctrl_ready) state <= WR_DATA;
        WR_DATA: if (wr_fire) begin
          if (last_beat) begin
            count     <= '0;
            offset    <= offset + cl;
            remaining <= remaining - cl;
            chunks    <= chunks + 8'd1;
            state     <= (remaining == cl) ? DONE : RD_REQ;
          end else begin
            count <= count + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Request fields and write data are forced to zero outside their own phase.
  assign dma_read_ctrl_valid        = (state == RD_REQ);
  assign dma_read_ctrl_data_index   = dma_read_ctrl_valid ? src_q + offset : '0;
  assign dma_read_ctrl_data_length  = dma_read_ctrl_valid ? cl : '0;
  assign dma_read_ctrl_data_size    = DMA_SIZE;
  assign dma_read_chnl_ready        = (state == RD_DATA) && (32'(count) < cl);
  assign dma_write_ctrl_valid       = (state == WR_REQ);
  assign dma_write_ctrl_data_index  = dma_write_ctrl_valid ? dst_q + offset : '0;
  assign dma_write_ctrl_data_length = dma_write_ctrl_valid ? cl : '0;
  assign dma_write_ctrl_data_size   = DMA_SIZE;
  assign dma_write_chnl_valid       = (state == WR_DATA);
  assign dma_write_chnl_data        = dma_write_chnl_valid ? buf_mem[count[AW-1:0]] : '0;
  assign acc_done                   = (state == DONE);
  assign debug                      = {16'h0000, chunks, 7'b0, zero_err};

endmodule

// File: tb/tb_audiodec_dma_gain.sv
// Self-checking bench for audiodec_dma_gain: table vectors, directed corner sequences and random stalled transfers.
module tb_audiodec_dma_gain;

  localparam int DMA_W = 64;
  localparam int CHUNK = 4;
`ifdef AUDIODEC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             conf_done;
  logic [31:0]      cfg0, cfg1, cfg2, cfg3;
  logic             dma_read_ctrl_valid, dma_read_ctrl_ready;
  logic [31:0]      dma_read_ctrl_data_index, dma_read_ctrl_data_length;
  logic [2:0]       dma_read_ctrl_data_size;
  logic             dma_read_chnl_valid, dma_read_chnl_ready;
  logic [DMA_W-1:0] dma_read_chnl_data;
  logic             dma_write_ctrl_valid, dma_write_ctrl_ready;
  logic [31:0]      dma_write_ctrl_data_index, dma_write_ctrl_data_length;
  logic [2:0]       dma_write_ctrl_data_size;
  logic             dma_write_chnl_valid, dma_write_chnl_ready;
  logic [DMA_W-1:0] dma_write_chnl_data;
  logic             acc_done;
  logic [31:0]      debug;

  audiodec_dma_gain #(.DMA_WIDTH(DMA_W), .CHUNK(CHUNK)) u_dut (
    .clk                        (clk),
    .rst                        (rst),
    .conf_done                  (conf_done),
    .conf_info_cfg_regs_0       (cfg0),
    .conf_info_cfg_regs_1       (cfg1),
    .conf_info_cfg_regs_2       (cfg2),
    .conf_info_cfg_regs_3       (cfg3),
    .dma_read_ctrl_valid        (dma_read_ctrl_valid),
    .dma_read_ctrl_ready        (dma_read_ctrl_ready),
    .dma_read_ctrl_data_index   (dma_read_ctrl_data_index),
    .dma_read_ctrl_data_length  (dma_read_ctrl_data_length),
    .dma_read_ctrl_data_size    (dma_read_ctrl_data_size),
    .dma_read_chnl_valid        (dma_read_chnl_valid),
    .dma_read_chnl_ready        (dma_read_chnl_ready),
    .dma_read_chnl_data         (dma_read_chnl_data),
    .dma_write_ctrl_valid       (dma_write_ctrl_valid),
    .dma_write_ctrl_ready       (dma_write_ctrl_ready),
    .dma_write_ctrl_data_index  (dma_write_ctrl_data_index),
    .dma_write_ctrl_data_length (dma_write_ctrl_data_length),
    .dma_write_ctrl_data_size   (dma_write_ctrl_data_size),
    .dma_write_chnl_valid       (dma_write_chnl_valid),
    .dma_write_chnl_ready       (dma_write_chnl_ready),
    .dma_write_chnl_data        (dma_write_chnl_data),
    .acc_done                   (acc_done),
    .debug                      (debug)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] gain; logic [63:0] din; logic [63:0] dout_sat; logic [63:0] dout_wrap; } vec_t;
  typedef struct { int idx; int len; } burst_t;
  typedef struct { int addr; logic [63:0] data; } beat_t;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] src_mem [256];
  burst_t      rd_bursts[$], wr_bursts[$];
  beat_t       wr_beats[$];
  int          wr_lat[$];
  bit          stall_en = 1'b0;
  bit          mon_en   = 1'b1;
  int          cyc_cnt = 0, last_rd_cyc = 0, acc_cnt = 0, ctrl_seen = 0, last_cycles = 0;
  int          rd_idx = 0, rd_left = 0, wr_idx = 0, wr_left = 0;
  bit          p_rc_stall = 0, p_wc_stall = 0, p_wd_stall = 0, p_wc_valid = 0, p_rd_taken = 0;
  logic [63:0] p_rc_f, p_wc_f, p_wd_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Reference: each lane is scaled with wide integer arithmetic, then clamped or truncated.
  function automatic logic [63:0] model_beat(input logic [63:0] din, input logic [15:0] g);
    logic [63:0] res = '0;
    for (int i = 0; i < 4; i++) begin
      longint s = longint'($signed(din[16*i +: 16]));
      longint r = (s * longint'(g)) >>> 8;
      if (SAT && r > 32767)  r = 32767;
      if (SAT && r < -32768) r = -32768;
      res[16*i +: 16] = r[15:0];
    end
    return res;
  endfunction

  // Memory-side DMA agent: drives readys/read data at negedge and logs the handshakes of the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      cyc_cnt++;
      if (!rst) begin
        dma_read_ctrl_ready  = 1'b0;
        dma_read_chnl_valid  = 1'b0;
        dma_read_chnl_data   = '0;
        dma_write_ctrl_ready = 1'b0;
        dma_write_chnl_ready = 1'b0;
        rd_left = 0; wr_left = 0;
        p_rc_stall = 0; p_wc_stall = 0; p_wd_stall = 0; p_wc_valid = 0; p_rd_taken = 0;
      end else begin
        if (mon_en && p_rc_stall) begin
          check("rd_ctrl_valid_hold", dma_read_ctrl_valid, 1);
          check("rd_ctrl_fields_hold", {dma_read_ctrl_data_index, dma_read_ctrl_data_length}, p_rc_f);
        end
        if (mon_en && p_wc_stall) begin
          check("wr_ctrl_valid_hold", dma_write_ctrl_valid, 1);
          check("wr_ctrl_fields_hold", {dma_write_ctrl_data_index, dma_write_ctrl_data_length}, p_wc_f);
        end
        if (mon_en && p_wd_stall) begin
          check("wr_chnl_valid_hold", dma_write_chnl_valid, 1);
          check("wr_chnl_data_hold", dma_write_chnl_data, p_wd_data);
        end
        dma_read_ctrl_ready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        dma_write_ctrl_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        dma_write_chnl_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!(dma_read_chnl_valid && !p_rd_taken))
          dma_read_chnl_valid = (rd_left > 0) && (stall_en ? 1'($urandom_range(0, 1)) : 1'b1);
        dma_read_chnl_data = src_mem[rd_idx[7:0]];

        p_rd_taken = 1'b0;
        if (dma_read_chnl_valid && dma_read_chnl_ready) begin
          rd_idx++; rd_left--; p_rd_taken = 1'b1;
          if (rd_left == 0) last_rd_cyc = cyc_cnt;
        end
        if (dma_read_ctrl_valid && dma_read_ctrl_ready) begin
          rd_bursts.push_back('{int'(dma_read_ctrl_data_index), int'(dma_read_ctrl_data_length)});
          rd_idx  = int'(dma_read_ctrl_data_index);
          rd_left = int'(dma_read_ctrl_data_length);
        end
        if (dma_write_ctrl_valid && !p_wc_valid) wr_lat.push_back(cyc_cnt - last_rd_cyc);
        if (dma_write_ctrl_valid && dma_write_ctrl_ready) begin
          wr_bursts.push_back('{int'(dma_write_ctrl_data_index), int'(dma_write_ctrl_data_length)});
          wr_idx  = int'(dma_write_ctrl_data_index);
          wr_left = int'(dma_write_ctrl_data_length);
        end
        if (dma_write_chnl_valid && dma_write_chnl_ready) begin
          wr_beats.push_back('{wr_idx, dma_write_chnl_data});
          wr_idx++; wr_left--;
        end
        if (acc_done) acc_cnt++;
        if (dma_read_ctrl_valid || dma_write_ctrl_valid) ctrl_seen++;

        p_rc_stall = dma_read_ctrl_valid && !dma_read_ctrl_ready;
        p_rc_f     = {dma_read_ctrl_data_index, dma_read_ctrl_data_length};
        p_wc_stall = dma_write_ctrl_valid && !dma_write_ctrl_ready;
        p_wc_f     = {dma_write_ctrl_data_index, dma_write_ctrl_data_length};
        p_wd_stall = dma_write_chnl_valid && !dma_write_chnl_ready;
        p_wd_data  = dma_write_chnl_data;
        p_wc_valid = dma_write_ctrl_valid;
      end
    end
  end

  task automatic run_xfer(input int len, input int src, input int dst, input logic [15:0] g, input string tag);
    int cyc, acc_base;
    rd_bursts.delete(); wr_bursts.delete(); wr_beats.delete(); wr_lat.delete();
    acc_base = acc_cnt;
    @(negedge clk);
    conf_done = 1'b1;
    cfg0 = 32'(len); cfg1 = 32'(src); cfg2 = 32'(dst); cfg3 = {16'hA5A5, g};
    @(negedge clk);
    conf_done = 1'b0;
    cyc = 1;
    while (!acc_done && cyc < 40 * len + 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_acc_done_seen"}, acc_done, 1);
    last_cycles = cyc;
    @(negedge clk);
    check({tag, "_acc_done_width"}, acc_done, 0);
    @(negedge clk);
    check({tag, "_acc_done_count"}, acc_cnt - acc_base, 1);
  endtask

  task automatic verify_xfer(input int len, input int src, input int dst, input logic [15:0] g, input string tag);
    int nb = (len + CHUNK - 1) / CHUNK;
    check({tag, "_rd_burst_cnt"}, rd_bursts.size(), nb);
    check({tag, "_wr_burst_cnt"}, wr_bursts.size(), nb);
    for (int b = 0; b < nb; b++) begin
      int el = imin(CHUNK, len - b * CHUNK);
      if (b < rd_bursts.size()) check({tag, "_rd_burst"}, {32'(rd_bursts[b].idx), 32'(rd_bursts[b].len)},
                                      {32'(src + b * CHUNK), 32'(el)});
      if (b < wr_bursts.size()) check({tag, "_wr_burst"}, {32'(wr_bursts[b].idx), 32'(wr_bursts[b].len)},
                                      {32'(dst + b * CHUNK), 32'(el)});
    end
    check({tag, "_beat_cnt"}, wr_beats.size(), len);
    for (int k = 0; k < len && k < wr_beats.size(); k++) begin
      logic [7:0] a = 8'(src + k);
      check({tag, "_beat_addr"}, wr_beats[k].addr, dst + k);
      check({tag, "_beat_data"}, wr_beats[k].data, model_beat(src_mem[a], g));
    end
    check({tag, "_debug"}, debug, 64'((nb % 256) << 8));
  endtask

  initial begin
    vec_t vecs[6];
    int   cyc, acc_base, ctrl_base;
    vecs[0] = '{16'h0200, 64'hFFFF_0001_C000_7000, 64'hFFFE_0002_8000_7FFF, 64'hFFFE_0002_8000_E000};
    vecs[1] = '{16'h0080, 64'h8000_0100_FFFF_0003, 64'hC000_0080_FFFF_0001, 64'hC000_0080_FFFF_0001};
    vecs[2] = '{16'h0100, 64'h1234_8000_7FFF_ABCD, 64'h1234_8000_7FFF_ABCD, 64'h1234_8000_7FFF_ABCD};
    vecs[3] = '{16'hFFFF, 64'h0000_0100_FFFF_0001, 64'h0000_7FFF_FF00_00FF, 64'h0000_FFFF_FF00_00FF};
    vecs[4] = '{16'h0000, 64'h8000_7FFF_1234_FFFF, 64'h0,                   64'h0};
    vecs[5] = '{16'h0300, 64'h9000_2000_3000_FFFE, 64'h8000_6000_7FFF_FFFA, 64'hB000_6000_9000_FFFA};

    for (int i = 0; i < 256; i++) src_mem[i] = {$urandom, $urandom};
    rst = 1'b0; conf_done = 1'b0; cfg0 = '0; cfg1 = '0; cfg2 = '0; cfg3 = '0;
    repeat (3) @(negedge clk);
    check("reset_valids", {dma_read_ctrl_valid, dma_read_chnl_ready, dma_write_ctrl_valid,
                           dma_write_chnl_valid, acc_done}, 0);
    check("reset_debug", debug, 0);
    check("size_fields", {dma_read_ctrl_data_size, dma_write_ctrl_data_size}, {3'b011, 3'b011});
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Zero length: straight to DONE, no DMA requests.
    ctrl_base = ctrl_seen;
    run_xfer(0, 5, 9, 16'h0100, "zero_len");
    check("zero_len_latency", last_cycles, 2);
    check("zero_len_debug", debug, 1);
    check("zero_len_no_ctrl", ctrl_seen - ctrl_base, 0);

    // Unity gain over a partial final chunk.
    for (int k = 0; k < 5; k++) src_mem[16 + k] = {$urandom, $urandom};
    run_xfer(5, 16'h10, 16'h40, 16'h0100, "unity");
    verify_xfer(5, 16'h10, 16'h40, 16'h0100, "unity");
    for (int k = 0; k < 5 && k < wr_beats.size(); k++) check("unity_passthrough", wr_beats[k].data, src_mem[16 + k]);
    check("unity_wr_req_count", wr_lat.size(), 2);
    if (wr_lat.size() > 0) check("unity_wr_req_latency", wr_lat[0], 1);

    // Table vectors, one beat each.
    for (int v = 0; v < 6; v++) begin
      src_mem[100 + v] = vecs[v].din;
      run_xfer(1, 100 + v, 200 + v, vecs[v].gain, "vec");
      verify_xfer(1, 100 + v, 200 + v, vecs[v].gain, "vec");
      if (wr_beats.size() > 0) check($sformatf("vec%0d_table", v), wr_beats[0].data,
                                     SAT ? vecs[v].dout_sat : vecs[v].dout_wrap);
    end

    // Random stalls, lengths and gains.
    stall_en = 1'b1;
    for (int t = 0; t < 4; t++) begin
      int          l = $urandom_range(1, 10);
      logic [15:0] g = 16'($urandom);
      run_xfer(l, t * 20, 128 + t * 20, g, "rand");
      verify_xfer(l, t * 20, 128 + t * 20, g, "rand");
    end
    run_xfer(37, 3, 60, 16'h01C0, "len37");
    verify_xfer(37, 3, 60, 16'h01C0, "len37");

    // Reset during the write phase abandons the transfer.
    @(negedge clk);
    conf_done = 1'b1; cfg0 = 32'd8; cfg1 = 32'd0; cfg2 = 32'd90; cfg3 = 32'h0000_0100;
    @(negedge clk);
    conf_done = 1'b0;
    cyc = 0;
    while (!dma_write_chnl_valid && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid_reached_wr_data", dma_write_chnl_valid, 1);
    mon_en = 1'b0;
    acc_base = acc_cnt;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_valids", {dma_read_ctrl_valid, dma_read_chnl_ready, dma_write_ctrl_valid,
                             dma_write_chnl_valid, acc_done}, 0);
    check("rst_mid_debug", debug, 0);
    check("rst_mid_wr_data", dma_write_chnl_data, 0);
    check("rst_mid_indices", {dma_read_ctrl_data_index, dma_write_ctrl_data_index}, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_mid_no_done", acc_cnt - acc_base, 0);
    mon_en = 1'b1;
    run_xfer(2, 40, 170, 16'h0240, "after_rst");
    verify_xfer(2, 40, 170, 16'h0240, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
